// File: rtl/encap_tag_parser.sv
// encap_tag_parser: AXI-Stream passthrough that picks the VSID and the inner destination MAC out of VXLAN/NVGRE
//   headers, matches them against a per-ID CAM and queues one route decision per packet.
// Latency: stream path 0 cycles; decision visible on dec_* the cycle after the last beat is accepted.
// Backpressure: stream stalls (tvalid/tready both gated) while the decision FIFO is full; dec_* is valid/ready.
// Ports:
//   aclk, areset            clock, asynchronous active-high reset
//   axis_in_* / axis_out_*  input / output stream; data, keep and last pass straight through
//   mode, added_offset      encapsulation type and extra header bytes ahead of L4 (sampled on first beat)
//   route_mask_in, next_can_have_vsid   previous-stage mask and VSID qualifier (sampled on last beat)
//   vsids, vsid_masks, vsid_must_match, mac_encap_addresses, mac_must_match   CAM (sampled on first beat)
//   dec_route_mask, dec_truncated, dec_valid, dec_ready   decision FIFO head
module encap_tag_parser #(
  parameter int AXIS_BUS_WIDTH    = 64,
  parameter int AXIS_ID_WIDTH     = 4,
  parameter int MAX_PACKET_LENGTH = 1522,
  parameter int MAX_ADDED_OFFSET  = 64,
  parameter int DEC_FIFO_DEPTH    = 4,
  localparam int NUM_AXIS_ID      = 2**AXIS_ID_WIDTH,
  localparam int NB               = AXIS_BUS_WIDTH / 8,
  localparam int AOW              = $clog2(MAX_ADDED_OFFSET + 1)
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [AXIS_BUS_WIDTH-1:0]   axis_in_tdata,
  input  logic [NB-1:0]               axis_in_tkeep,
  input  logic                        axis_in_tlast,
  input  logic                        axis_in_tvalid,
  output logic                        axis_in_tready,
  output logic [AXIS_BUS_WIDTH-1:0]   axis_out_tdata,
  output logic [NB-1:0]               axis_out_tkeep,
  output logic                        axis_out_tlast,
  output logic                        axis_out_tvalid,
  input  logic                        axis_out_tready,
  input  logic [1:0]                  mode,
  input  logic [AOW-1:0]              added_offset,
  input  logic [NUM_AXIS_ID-1:0]      route_mask_in,
  input  logic                        next_can_have_vsid,
  input  logic [NUM_AXIS_ID*24-1:0]   vsids,
  input  logic [NUM_AXIS_ID*24-1:0]   vsid_masks,
  input  logic [NUM_AXIS_ID-1:0]      vsid_must_match,
  input  logic [NUM_AXIS_ID*48-1:0]   mac_encap_addresses,
  input  logic [NUM_AXIS_ID-1:0]      mac_must_match,
  output logic [NUM_AXIS_ID-1:0]      dec_route_mask,
  output logic                        dec_truncated,
  output logic                        dec_valid,
  input  logic                        dec_ready
);

  localparam int LNB       = $clog2(NB);
  localparam int MAX_BEATS = (MAX_PACKET_LENGTH + NB - 1) / NB;
  localparam int BCW       = $clog2(MAX_BEATS + 1);
  localparam int PTRW      = $clog2(DEC_FIFO_DEPTH);
  localparam int CNTW      = $clog2(DEC_FIFO_DEPTH + 1);
  localparam int NF        = 9;  // 3 VSID bytes followed by 6 MAC bytes

  // ---------------- stream gating ----------------
  logic [CNTW-1:0] count;
  logic            full;
  logic            beat;
  logic            last_beat;
  logic            first_beat;
  logic [BCW-1:0]  beat_cnt;

  assign full            = (count == CNTW'(DEC_FIFO_DEPTH));
  assign axis_out_tvalid = axis_in_tvalid & ~full;
  assign axis_in_tready  = axis_out_tready & ~full;
  assign axis_out_tdata  = axis_in_tdata;
  assign axis_out_tkeep  = axis_in_tkeep;
  assign axis_out_tlast  = axis_in_tlast;
  assign beat            = axis_in_tvalid & axis_in_tready;
  assign last_beat       = beat & axis_in_tlast;
  // A saturated counter never returns to zero mid-packet, so zero means "next beat starts a packet".
  assign first_beat      = (beat_cnt == '0);

  // ---------------- per-packet configuration ----------------
  logic [1:0]                mode_r;
  logic [AOW-1:0]            off_r;
  logic [NUM_AXIS_ID*24-1:0] vsids_r, vmasks_r;
  logic [NUM_AXIS_ID*48-1:0] macs_r;
  logic [NUM_AXIS_ID-1:0]    vmm_r, mmm_r;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      mode_r   <= '0;
      off_r    <= '0;
      vsids_r  <= '0;
      vmasks_r <= '0;
      macs_r   <= '0;
      vmm_r    <= '0;
      mmm_r    <= '0;
    end else if (beat && first_beat) begin
      mode_r   <= mode;
      off_r    <= added_offset;
      vsids_r  <= vsids;
      vmasks_r <= vsid_masks;
      macs_r   <= mac_encap_addresses;
      vmm_r    <= vsid_must_match;
      mmm_r    <= mac_must_match;
    end
  end

  // On the first beat the registers are not loaded yet, so the live inputs are used directly;
  // this also covers single-beat packets.
  logic [1:0]                mode_e;
  logic [AOW-1:0]            off_e;
  logic [NUM_AXIS_ID*24-1:0] vsids_e, vmasks_e;
  logic [NUM_AXIS_ID*48-1:0] macs_e;
  logic [NUM_AXIS_ID-1:0]    vmm_e, mmm_e;

  assign mode_e   = first_beat ? mode                : mode_r;
  assign off_e    = first_beat ? added_offset        : off_r;
  assign vsids_e  = first_beat ? vsids               : vsids_r;
  assign vmasks_e = first_beat ? vsid_masks          : vmasks_r;
  assign macs_e   = first_beat ? mac_encap_addresses : macs_r;
  assign vmm_e    = first_beat ? vsid_must_match     : vmm_r;
  assign mmm_e    = first_beat ? mac_must_match      : mmm_r;

  // ---------------- field byte capture ----------------
  logic                  encap_e;
  logic [15:0]           base;
  logic [NF-1:0][15:0]   fpos;
  logic [NF-1:0][7:0]    lane_byte;
  logic [NF-1:0][7:0]    cap;
  logic [NF-1:0][7:0]    cur_byte;
  logic [NF-1:0]         seen;
  logic [NF-1:0]         hit;
  logic [NF-1:0]         cur_seen;

  always_comb begin
    encap_e = (mode_e == 2'd1) || (mode_e == 2'd2);
    // VXLAN carries an 8-byte UDP header before its own header; NVGRE sits directly after IP.
    base    = 16'd34 + 16'(off_e) + ((mode_e == 2'd1) ? 16'd8 : 16'd0);
    for (int j = 0; j < NF; j++) begin
      // VSID at base+4..6, byte base+7 skipped, MAC at base+8..13
      fpos[j]      = base + ((j < 3) ? 16'(4 + j) : 16'(5 + j));
      lane_byte[j] = axis_in_tdata[int'(fpos[j][LNB-1:0])*8 +: 8];
      hit[j]       = beat & encap_e & ((fpos[j] >> LNB) == 16'(beat_cnt))
                   & axis_in_tkeep[fpos[j][LNB-1:0]];
      cur_seen[j]  = seen[j] | hit[j];
      cur_byte[j]  = hit[j] ? lane_byte[j] : cap[j];
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      beat_cnt <= '0;
      seen     <= '0;
      cap      <= '0;
    end else if (last_beat) begin
      beat_cnt <= '0;
      seen     <= '0;
      cap      <= '0;
    end else if (beat) begin
      if (beat_cnt != BCW'(MAX_BEATS)) beat_cnt <= beat_cnt + 1'b1;
      for (int j = 0; j < NF; j++) begin
        if (hit[j]) begin
          seen[j] <= 1'b1;
          cap[j]  <= lane_byte[j];
        end
      end
    end
  end

  // ---------------- CAM match and decision ----------------
  logic [23:0]            vsid;
  logic [47:0]            mac;
  logic                   vsid_all, mac_all;
  logic [NUM_AXIS_ID-1:0] vpass, mpass;
  logic [NUM_AXIS_ID-1:0] new_mask;
  logic                   new_trunc;

  assign vsid      = {cur_byte[0], cur_byte[1], cur_byte[2]};
  assign mac       = {cur_byte[3], cur_byte[4], cur_byte[5], cur_byte[6], cur_byte[7], cur_byte[8]};
  assign vsid_all  = &cur_seen[2:0];
  assign mac_all   = &cur_seen[8:3];
  assign new_mask  = route_mask_in & vpass & mpass;
  assign new_trunc = encap_e & ~(&cur_seen);

  always_comb begin
    for (int k = 0; k < NUM_AXIS_ID; k++) begin
      vpass[k] = ~vmm_e[k] | (vsid_all & next_can_have_vsid &
                 (((vsid ^ vsids_e[k*24 +: 24]) & vmasks_e[k*24 +: 24]) == 24'd0));
      mpass[k] = ~mmm_e[k] | (mac_all & (mac == macs_e[k*48 +: 48]));
    end
  end

  // ---------------- decision FIFO ----------------
  logic [NUM_AXIS_ID:0] mem [DEC_FIFO_DEPTH];
  logic [PTRW-1:0]      wr_ptr, rd_ptr;
  logic                 push, pop;

  assign push      = last_beat;
  assign pop       = dec_valid & dec_ready;
  assign dec_valid = (count != '0);
  assign {dec_route_mask, dec_truncated} = dec_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr] <= {new_mask, new_trunc};
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTRW'(DEC_FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTRW'(DEC_FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_encap_tag_parser.sv
// Directed bench for encap_tag_parser with the default parameters (64-bit bus, 16 CAM entries, 4-deep FIFO).
module tb_encap_tag_parser;
  localparam int NB = 8;
  localparam int N  = 16;

  logic          aclk = 1'b0;
  logic          areset;
  logic [63:0]   axis_in_tdata;
  logic [7:0]    axis_in_tkeep;
  logic          axis_in_tlast;
  logic          axis_in_tvalid;
  logic          axis_in_tready;
  logic [63:0]   axis_out_tdata;
  logic [7:0]    axis_out_tkeep;
  logic          axis_out_tlast;
  logic          axis_out_tvalid;
  logic          axis_out_tready;
  logic [1:0]    mode;
  logic [6:0]    added_offset;
  logic [N-1:0]  route_mask_in;
  logic          next_can_have_vsid;
  logic [N*24-1:0] vsids, vsid_masks;
  logic [N-1:0]  vsid_must_match;
  logic [N*48-1:0] mac_encap_addresses;
  logic [N-1:0]  mac_must_match;
  logic [N-1:0]  dec_route_mask;
  logic          dec_truncated;
  logic          dec_valid;
  logic          dec_ready;

  encap_tag_parser dut (
    .aclk(aclk), .areset(areset),
    .axis_in_tdata(axis_in_tdata), .axis_in_tkeep(axis_in_tkeep), .axis_in_tlast(axis_in_tlast),
    .axis_in_tvalid(axis_in_tvalid), .axis_in_tready(axis_in_tready),
    .axis_out_tdata(axis_out_tdata), .axis_out_tkeep(axis_out_tkeep), .axis_out_tlast(axis_out_tlast),
    .axis_out_tvalid(axis_out_tvalid), .axis_out_tready(axis_out_tready),
    .mode(mode), .added_offset(added_offset), .route_mask_in(route_mask_in),
    .next_can_have_vsid(next_can_have_vsid), .vsids(vsids), .vsid_masks(vsid_masks),
    .vsid_must_match(vsid_must_match), .mac_encap_addresses(mac_encap_addresses),
    .mac_must_match(mac_must_match), .dec_route_mask(dec_route_mask),
    .dec_truncated(dec_truncated), .dec_valid(dec_valid), .dec_ready(dec_ready)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;
  logic [7:0] pkt [256];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Filler byte i = i, then VSID / MAC written big-endian at the given byte positions.
  task automatic build_pkt(input logic [23:0] v, input int vpos, input logic [47:0] m, input int mpos);
    for (int i = 0; i < 256; i++) pkt[i] = 8'(i);
    for (int b = 0; b < 3; b++) pkt[vpos + b] = v[23 - 8*b -: 8];
    for (int b = 0; b < 6; b++) pkt[mpos + b] = m[47 - 8*b -: 8];
  endtask

  // Entry k: VSID 0x10000k, MAC 0A:00:00:00:00:0k, both enforced; entry 2 is the test 1 target.
  task automatic cam_default();
    for (int k = 0; k < N; k++) begin
      vsids[k*24 +: 24]               = 24'h100000 + 24'(k);
      vsid_masks[k*24 +: 24]          = 24'hFFFFFF;
      mac_encap_addresses[k*48 +: 48] = 48'h0A0000000000 + 48'(k);
    end
    vsids[2*24 +: 24]               = 24'hABCDEF;
    mac_encap_addresses[2*48 +: 48] = 48'h020000000007;
    vsid_must_match = 16'hFFFF;
    mac_must_match  = 16'hFFFF;
  endtask

  // Sends the first nbeats beats of a len-byte packet from pkt[].
  task automatic send_pkt(input int len, input int nbeats);
    int nb;
    logic [63:0] d;
    logic [7:0]  kp;
    int t;
    nb = (len + NB - 1) / NB;
    for (int b = 0; b < nbeats; b++) begin
      @(negedge aclk);
      for (int i = 0; i < NB; i++) begin
        d[i*8 +: 8] = pkt[b*NB + i];
        kp[i]       = (b*NB + i) < len;
      end
      axis_in_tdata  = d;
      axis_in_tkeep  = kp;
      axis_in_tlast  = (b == nb - 1);
      axis_in_tvalid = 1'b1;
      #1;
      if (b == 0) chk("pass_tdata", axis_out_tdata, d);
      t = 0;
      while (!axis_in_tready && t < 200) begin
        @(negedge aclk);
        t++;
      end
      if (t == 200) chk("tready_timeout", 64'(axis_in_tready), 64'd1);
      @(posedge aclk);
      #1;
      axis_in_tvalid = 1'b0;
      axis_in_tlast  = 1'b0;
    end
  endtask

  task automatic get_dec(input string tag, input logic [15:0] em, input logic et);
    @(negedge aclk);
    chk({tag, "_valid"}, 64'(dec_valid), 64'd1);
    chk({tag, "_mask"}, 64'(dec_route_mask), 64'(em));
    chk({tag, "_trunc"}, 64'(dec_truncated), 64'(et));
    dec_ready = 1'b1;
    @(posedge aclk);
    #1;
    dec_ready = 1'b0;
  endtask

  initial begin
    areset = 1'b1;
    axis_in_tdata = '0; axis_in_tkeep = '0; axis_in_tlast = 1'b0; axis_in_tvalid = 1'b0;
    axis_out_tready = 1'b1; dec_ready = 1'b0;
    mode = 2'd0; added_offset = '0; route_mask_in = 16'hFFFF; next_can_have_vsid = 1'b1;
    cam_default();

    // reset state
    repeat (3) @(negedge aclk);
    chk("rst_dec_valid", 64'(dec_valid), 64'd0);
    chk("rst_dec_mask", 64'(dec_route_mask), 64'd0);
    chk("rst_dec_trunc", 64'(dec_truncated), 64'd0);
    chk("rst_tready_hi", 64'(axis_in_tready), 64'd1);
    axis_out_tready = 1'b0; #1;
    chk("rst_tready_lo", 64'(axis_in_tready), 64'd0);
    axis_out_tready = 1'b1;
    areset = 1'b0;

    // 1: VXLAN aligned
    mode = 2'd1; added_offset = 7'd0;
    build_pkt(24'hABCDEF, 46, 48'h020000000007, 50);
    send_pkt(64, 8);
    get_dec("vxlan_aligned", 16'h0004, 1'b0);

    // 2: odd offset, then masked VSID compare, then same VSID without the mask
    added_offset = 7'd3;
    build_pkt(24'hABCDEF, 49, 48'h020000000007, 53);
    send_pkt(64, 8);
    get_dec("vxlan_odd", 16'h0004, 1'b0);
    vsid_masks[2*24 +: 24] = 24'hFFFF00;
    build_pkt(24'hABCD00, 49, 48'h020000000007, 53);
    send_pkt(64, 8);
    get_dec("vsid_masked", 16'h0004, 1'b0);
    vsid_masks[2*24 +: 24] = 24'hFFFFFF;
    send_pkt(64, 8);
    get_dec("vsid_unmasked", 16'h0000, 1'b0);

    // 3: NVGRE, VSID enforced on entry 5 only
    cam_default();
    mode = 2'd2; added_offset = 7'd0;
    vsids[5*24 +: 24] = 24'h123456;
    vsid_must_match = 16'h0020; mac_must_match = 16'h0000;
    build_pkt(24'h123456, 38, 48'h0, 42);
    next_can_have_vsid = 1'b0;
    send_pkt(64, 8);
    get_dec("nvgre_novsid", 16'hFFDF, 1'b0);
    next_can_have_vsid = 1'b1;
    send_pkt(64, 8);
    get_dec("nvgre_vsid", 16'hFFFF, 1'b0);

    // 4: VXLAN packet ending before the MAC
    mode = 2'd1;
    vsid_must_match = 16'h0000; mac_must_match = 16'h00F0;
    build_pkt(24'hABCDEF, 46, 48'h020000000007, 50);
    send_pkt(50, 7);
    get_dec("truncated", 16'hFF0F, 1'b1);

    // mode 0 and 3: nothing captured, enforced entries fail, never truncated
    mode = 2'd0; vsid_must_match = 16'h0003; mac_must_match = 16'h0000;
    send_pkt(64, 8);
    get_dec("mode0", 16'hFFFC, 1'b0);
    mode = 2'd3; vsid_must_match = 16'h0000; mac_must_match = 16'h0300;
    send_pkt(64, 8);
    get_dec("mode3", 16'hFCFF, 1'b0);

    // single-beat packet takes its mode from that beat
    mode = 2'd1; mac_must_match = 16'h0000;
    send_pkt(8, 1);
    get_dec("single_beat", 16'hFFFF, 1'b1);

    // 5: fill the decision FIFO, stall the stream, drain in order
    build_pkt(24'hABCDEF, 46, 48'h020000000007, 50);
    for (int p = 0; p < 4; p++) begin
      route_mask_in = 16'(1 << p);
      send_pkt(64, 8);
    end
    chk("full_tready", 64'(axis_in_tready), 64'd0);
    chk("full_valid", 64'(dec_valid), 64'd1);
    route_mask_in = 16'h0010;
    fork
      send_pkt(64, 8);
      begin
        repeat (4) @(negedge aclk);
        #1;
        chk("stall_out_tvalid", 64'(axis_out_tvalid), 64'd0);
        chk("stall_tready", 64'(axis_in_tready), 64'd0);
        for (int p = 0; p < 4; p++) get_dec($sformatf("order%0d", p), 16'(1 << p), 1'b0);
      end
    join
    get_dec("fifth", 16'h0010, 1'b0);

    // 6: reset mid-packet, then a fresh packet
    route_mask_in = 16'hFFFF;
    cam_default();
    mode = 2'd1; added_offset = 7'd0;
    send_pkt(64, 3);
    @(negedge aclk);
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    chk("abort_no_dec", 64'(dec_valid), 64'd0);
    send_pkt(64, 8);
    get_dec("after_abort", 16'h0004, 1'b0);
    @(negedge aclk);
    chk("drained", 64'(dec_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
